pdm_mic_capture: RTL and testbench
==================================

Name: pdm_mic_capture

Overview:
- Capture front-end for the on-board PDM microphone; drives pdm_m_clk and samples pdm_m_data_i.
- Packs the 1-bit PDM stream into WORD_W-bit words and buffers them in a small FIFO.
- Presents the words on a valid/ready stream to the audio DMA/decimation path inside the system block diagram.
- Drives pdm_audio_shutdown so the audio path stays off until capture is enabled.

Parameters:
HALF_PERIOD, 32, clk cycles per pdm_m_clk half-period (100 MHz / 64 = 1.5625 MHz); legal range ≥2
WORD_W, 32, PDM bits packed per output word
FIFO_DEPTH, 16, words buffered; power of two, ≥2

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  capture enable (level)
pdm_m_clk  out  1  microphone bit clock
pdm_m_data_i  in  1  microphone data, asynchronous to clk
pdm_audio_shutdown  out  1  registered copy of enable (1 = audio path powered)
m_tdata  out  WORD_W  packed PDM word, first-captured bit at MSB
m_tvalid  out  1  m_tdata valid
m_tready  in  1  consumer accepts the word when m_tvalid & m_tready
fifo_level  out  $clog2(FIFO_DEPTH+1)  words held
overflow  out  1  sticky: a completed word was dropped
clear_overflow  in  1  single-cycle clear of overflow

Behaviour:
- Reset: rst is synchronous, active-high, and wins over everything. After the reset cycle:
  - pdm_m_clk=0, pdm_audio_shutdown=0, m_tvalid=0, m_tdata=0, fifo_level=0, overflow=0.
  - Half-period counter, bit counter, shift register and synchroniser are all cleared; the FIFO is emptied.
- Input sync: pdm_m_data_i passes through a 2-FF synchroniser; data_s is the second-stage output.
- Clock generation:
  - While enable=1, the half counter counts 0..HALF_PERIOD-1 and wraps.
  - pdm_m_clk toggles (registered) on the cycle the counter equals HALF_PERIOD-1.
  - First rise of pdm_m_clk is HALF_PERIOD cycles after the first enabled cycle; period is 2*HALF_PERIOD.
- Enable low:
  - Counter held at 0; pdm_m_clk forced 0 on the next cycle.
  - Bit counter and shift register cleared, so a partial word is discarded.
  - FIFO contents are kept and still drainable.
- Sampling: on the cycle pdm_m_clk is registered 0→1, data_s is shifted in.
  - Shift rule: shreg <= {shreg[WORD_W-2:0], data_s}.
  - The bit counter (0..WORD_W-1) increments on each sample.
- Word complete: on the sample where the bit counter = WORD_W-1:
  - The full word (including that bit) is pushed to the FIFO on the next clk edge.
  - The bit counter wraps to 0.
- FIFO: synchronous, show-ahead.
  - m_tdata/m_tvalid reflect the head entry, registered.
  - A push into an empty FIFO gives m_tvalid=1 one cycle after the push cycle.
  - Pop happens when m_tvalid & m_tready; m_tdata holds when m_tvalid=1 and m_tready=0.
  - m_tdata is don't-care when m_tvalid=0; bench checks it only with m_tvalid=1.
- Full / simultaneous events:
  - Push while full with no pop: word dropped, fifo_level unchanged, overflow<=1.
  - Push while full with a pop in the same cycle: push accepted, level unchanged.
  - Push and pop together when not full: level unchanged.
  - overflow set and clear_overflow in the same cycle: set wins.
- Pointer and level arithmetic:
  - Read/write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - fifo_level is an explicit counter, 0..FIFO_DEPTH.
- pdm_audio_shutdown = enable delayed one cycle.

Decomposition:
- Shared package pdm_pkg holds:
  - Default constants PDM_HALF_PERIOD=32, PDM_WORD_W=32, PDM_FIFO_DEPTH=16.
  - Function clog2_p1 for the level width.
- One sub-module, pdm_word_fifo (parameters WIDTH, DEPTH):
  - Ports: push/din/full, valid/ready/dout, level.
  - The top holds the clock divider, synchroniser, shifter and overflow logic.

Test Plan (HALF_PERIOD=2, WORD_W=32, FIFO_DEPTH=4 unless stated):
- Reset: hold rst 3 cycles with enable=1 and m_tready=1 → pdm_m_clk=0, m_tvalid=0, fifo_level=0, overflow=0, pdm_audio_shutdown=0 for the cycle after each reset cycle.
- Clock: enable 0→1 at cycle 0 → pdm_m_clk rises at cycle 2, falls at 4, rises at 6 (period 4); enable→0 → pdm_m_clk=0 within 1 cycle and stays 0.
- Packing: data_s=1,0,1,0… on successive rises, m_tready=1 → first word 0xAAAAAAAA, m_tvalid high exactly 1 cycle per word, one word per 128 clk.
- Overflow/backpressure: m_tready=0, constant 1 for 5 words → fifo_level=4, overflow=1; then m_tready=1 → four 0xFFFFFFFF words drained; pulse clear_overflow → overflow=0; clear_overflow and a drop in the same cycle → overflow stays 1.
- Partial discard: 10 bits of 0, enable low 5 cycles, re-enable, 32 bits of 1 → exactly one word, 0xFFFFFFFF.
- Reset mid-stream: rst after 2 words queued and 17 bits shifted → level 0, m_tvalid=0; the next word after release is built from post-reset bits only.

Source files
------------

// File: rtl/pdm_pkg.sv
// Shared constants and helpers for the PDM microphone capture path.
package pdm_pkg;

  localparam int PDM_HALF_PERIOD = 32;
  localparam int PDM_WORD_W      = 32;
  localparam int PDM_FIFO_DEPTH  = 16;

  // Width needed to hold a count from 0 up to and including depth.
  function automatic int clog2_p1(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pdm_word_fifo.sv
// Show-ahead word FIFO with registered head outputs and an explicit level counter.
module pdm_word_fifo
  import pdm_pkg::*;
#(
  parameter int WIDTH = PDM_WORD_W,
  parameter int DEPTH = PDM_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  output logic                         full,
  output logic                         valid,
  input  logic                         ready,
  output logic [WIDTH-1:0]             dout,
  output logic [clog2_p1(DEPTH)-1:0]   level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = clog2_p1(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_ptr_n;
  logic [LEVEL_W-1:0] level_n;
  logic               pop;
  logic               do_push;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a pop.
  assign full    = (level == LEVEL_W'(DEPTH));
  assign pop     = valid & ready;
  assign do_push = push & (~full | pop);

  // Next read pointer and next fill level for this cycle's push/pop combination.
  always_comb begin
    rd_ptr_n = rd_ptr;
    level_n  = level;
    if (pop) begin
      rd_ptr_n = rd_ptr + PTR_W'(1);
    end
    case ({do_push, pop})
      2'b10:   level_n = level + LEVEL_W'(1);
      2'b01:   level_n = level - LEVEL_W'(1);
      default: level_n = level;
    endcase
  end

  // Storage write; contents need no reset because the pointers define what is live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, level and registered head; the incoming word bypasses storage when it becomes the only entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_ptr_n;
      level  <= level_n;
      valid  <= (level_n != '0);
      if (do_push && (level_n == LEVEL_W'(1))) begin
        dout <= din;
      end else if (level_n != '0) begin
        dout <= mem[rd_ptr_n];
      end
    end
  end

endmodule

// File: rtl/pdm_mic_capture.sv
// PDM microphone front-end: bit clock generation, input sync, word packing and buffered stream output.
module pdm_mic_capture
  import pdm_pkg::*;
#(
  parameter int HALF_PERIOD = PDM_HALF_PERIOD,
  parameter int WORD_W      = PDM_WORD_W,
  parameter int FIFO_DEPTH  = PDM_FIFO_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  output logic                              pdm_m_clk,
  input  logic                              pdm_m_data_i,
  output logic                              pdm_audio_shutdown,
  output logic [WORD_W-1:0]                 m_tdata,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic [clog2_p1(FIFO_DEPTH)-1:0]   fifo_level,
  output logic                              overflow,
  input  logic                              clear_overflow
);

  localparam int CNT_W = $clog2(HALF_PERIOD);
  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  logic              sync_ff1;
  logic              data_s;
  logic [CNT_W-1:0]  half_cnt;
  logic              rise;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic              push_req;
  logic [WORD_W-1:0] push_word;
  logic              fifo_full;

  // The bit clock goes high on this edge, which is also the moment we take a sample.
  assign rise = enable && (half_cnt == CNT_LAST) && !pdm_m_clk;

  // Two-stage synchroniser for the asynchronous microphone data line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff1 <= 1'b0;
      data_s   <= 1'b0;
    end else begin
      sync_ff1 <= pdm_m_data_i;
      data_s   <= sync_ff1;
    end
  end

  // Half-period divider producing the microphone clock; disabling parks it low.
  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt  <= '0;
      pdm_m_clk <= 1'b0;
    end else if (!enable) begin
      half_cnt  <= '0;
      pdm_m_clk <= 1'b0;
    end else if (half_cnt == CNT_LAST) begin
      half_cnt  <= '0;
      pdm_m_clk <= ~pdm_m_clk;
    end else begin
      half_cnt  <= half_cnt + CNT_W'(1);
    end
  end

  // Shift samples in MSB-first and hand a finished word to the FIFO one cycle later; disabling drops a partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      push_req  <= 1'b0;
      push_word <= '0;
    end else begin
      push_req <= 1'b0;
      if (!enable) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (rise) begin
        shreg <= {shreg[WORD_W-2:0], data_s};
        if (bit_cnt == BIT_LAST) begin
          bit_cnt   <= '0;
          push_req  <= 1'b1;
          push_word <= {shreg[WORD_W-2:0], data_s};
        end else begin
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !(m_tvalid && m_tready)) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Audio path power follows enable with one cycle of delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      pdm_audio_shutdown <= 1'b0;
    end else begin
      pdm_audio_shutdown <= enable;
    end
  end

  pdm_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (push_word),
    .full  (fifo_full),
    .valid (m_tvalid),
    .ready (m_tready),
    .dout  (m_tdata),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Scoreboard bench for pdm_mic_capture with a small clock divider and a 4-deep FIFO.
module tb_pdm_mic_capture;

  localparam int HP = 2;
  localparam int WW = 32;
  localparam int FD = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          pdm_m_clk;
  logic          pdm_m_data_i;
  logic          pdm_audio_shutdown;
  logic [WW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          clear_overflow;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int pop_count = 0;
  int base      = 0;
  logic [WW-1:0] exp_q[$];
  int            pop_cycles[$];
  logic [7:0]    clk_pat = 8'b11001100;

  pdm_mic_capture #(
    .HALF_PERIOD (HP),
    .WORD_W      (WW),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .pdm_m_clk          (pdm_m_clk),
    .pdm_m_data_i       (pdm_m_data_i),
    .pdm_audio_shutdown (pdm_audio_shutdown),
    .m_tdata            (m_tdata),
    .m_tvalid           (m_tvalid),
    .m_tready           (m_tready),
    .fifo_level         (fifo_level),
    .overflow           (overflow),
    .clear_overflow     (clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive nbits of word MSB-first, changing data just after each bit-clock rise.
  task automatic applyStimulus(input logic [WW-1:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (i == 0 && !enable) begin
        pdm_m_data_i = word[WW-1];
        tick(2);
        enable = 1'b1;
      end else begin
        pdm_m_data_i = word[WW-1-i];
      end
      @(posedge pdm_m_clk);
      #1;
    end
  endtask

  // Monitor: every accepted word is popped from the scoreboard and compared.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst === 1'b0 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
        pop_count++;
        pop_cycles.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got 0x%08h, expected no word", m_tdata);
        end else begin
          checkOutput("word", m_tdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    rst            = 1'b1;
    enable         = 1'b1;
    m_tready       = 1'b1;
    pdm_m_data_i   = 1'b0;
    clear_overflow = 1'b0;

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("rst_pdm_clk", pdm_m_clk, 0);
      checkOutput("rst_valid", m_tvalid, 0);
      checkOutput("rst_level", fifo_level, 0);
      checkOutput("rst_overflow", overflow, 0);
      checkOutput("rst_shutdown", pdm_audio_shutdown, 0);
    end
    rst    = 1'b0;
    enable = 1'b0;
    tick(3);

    $display("[TB] clock generation");
    enable = 1'b1;
    checkOutput("clk_cycle0", pdm_m_clk, 0);
    for (int c = 1; c < 8; c++) begin
      tick(1);
      checkOutput($sformatf("clk_cycle%0d", c), pdm_m_clk, clk_pat[c]);
      if (c == 1) checkOutput("shutdown_on", pdm_audio_shutdown, 1);
    end
    enable = 1'b0;
    for (int c = 8; c < 12; c++) begin
      tick(1);
      checkOutput($sformatf("clk_off_cycle%0d", c), pdm_m_clk, 0);
      if (c == 8) checkOutput("shutdown_off", pdm_audio_shutdown, 0);
    end
    tick(2);

    $display("[TB] packing");
    m_tready = 1'b1;
    pop_cycles.delete();
    for (int w = 0; w < 3; w++) begin
      exp_q.push_back(32'hAAAAAAAA);
      applyStimulus(32'hAAAAAAAA, 32);
    end
    enable = 1'b0;
    tick(6);
    checkOutput("pack_count", pop_cycles.size(), 3);
    if (pop_cycles.size() >= 3) begin
      checkOutput("pack_spacing1", pop_cycles[1] - pop_cycles[0], 128);
      checkOutput("pack_spacing2", pop_cycles[2] - pop_cycles[1], 128);
    end
    checkOutput("pack_level", fifo_level, 0);
    checkOutput("pack_valid", m_tvalid, 0);

    $display("[TB] overflow and backpressure");
    m_tready = 1'b0;
    for (int w = 0; w < 5; w++) applyStimulus(32'hFFFFFFFF, 32);
    enable = 1'b0;
    tick(3);
    checkOutput("ovf_level", fifo_level, 4);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_valid", m_tvalid, 1);
    for (int w = 0; w < 4; w++) exp_q.push_back(32'hFFFFFFFF);
    m_tready = 1'b1;
    tick(8);
    checkOutput("drain_level", fifo_level, 0);
    checkOutput("ovf_sticky", overflow, 1);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    checkOutput("ovf_cleared", overflow, 0);

    m_tready = 1'b0;
    for (int w = 0; w < 4; w++) applyStimulus(32'hFFFFFFFF, 32);
    applyStimulus(32'hFFFFFFFF, 32);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    enable = 1'b0;
    checkOutput("ovf_set_wins", overflow, 1);
    tick(2);
    checkOutput("ovf2_level", fifo_level, 4);
    for (int w = 0; w < 4; w++) exp_q.push_back(32'hFFFFFFFF);
    m_tready = 1'b1;
    tick(8);
    checkOutput("drain2_level", fifo_level, 0);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    checkOutput("ovf2_cleared", overflow, 0);

    $display("[TB] partial word discard");
    m_tready = 1'b1;
    base = pop_count;
    applyStimulus(32'h00000000, 10);
    enable = 1'b0;
    tick(3);
    exp_q.push_back(32'hFFFFFFFF);
    applyStimulus(32'hFFFFFFFF, 32);
    enable = 1'b0;
    tick(6);
    checkOutput("partial_count", pop_count - base, 1);

    $display("[TB] reset mid-stream");
    m_tready = 1'b0;
    applyStimulus(32'hFFFFFFFF, 32);
    applyStimulus(32'hFFFFFFFF, 32);
    applyStimulus(32'hFFFFFFFF, 17);
    checkOutput("pre_rst_level", fifo_level, 2);
    pdm_m_data_i = 1'b0;
    rst = 1'b1;
    tick(1);
    checkOutput("mid_rst_level", fifo_level, 0);
    checkOutput("mid_rst_valid", m_tvalid, 0);
    checkOutput("mid_rst_pdm_clk", pdm_m_clk, 0);
    rst      = 1'b0;
    m_tready = 1'b1;
    base     = pop_count;
    exp_q.push_back(32'h12345678);
    applyStimulus(32'h12345678, 32);
    enable = 1'b0;
    tick(6);
    checkOutput("post_rst_count", pop_count - base, 1);

    tick(4);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
